sq_rt_display: RTL

Downstream display stage for the square-root finder: consumes the 8-bit operand `a` and the 4-bit result `sqrt`, converts the selected value to decimal with a sequential double-dabble converter, and drives a 4-digit multiplexed common-anode seven-segment display. Conversion results are double-buffered so the display never shows a partially converted value. It sits beside the finder top, fed by the same switch inputs and the finder's `sqrt` output.

---
 rtl/sq_rt_pkg.sv | 47 ++++
 rtl/sq_rt_display_bcd.sv | 66 ++++++
 rtl/sq_rt_display.sv | 103 ++++++++++
 3 files changed

// File: rtl/sq_rt_pkg.sv
// Shared constants for the square-root display stage: glyphs, anode patterns,
// converter FSM states and the BCD digit layout.
package sq_rt_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    typedef struct packed {
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
    } bcd_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sq_rt_display_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble), one
// add-3/shift iteration per clock.
module bin_to_bcd8
    import sq_rt_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state, state_nxt;
    logic [2:0]  iter;
    logic [7:0]  sh;
    logic [11:0] adj;

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (iter == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction applied to every digit before the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++)
            if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            iter <= '0;
            sh   <= '0;
            bcd  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sh   <= bin;
                    bcd  <= '0;
                    iter <= '0;
                end
                SHIFT: begin
                    {bcd, sh} <= {adj[10:0], sh, 1'b0};
                    iter      <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/sq_rt_display.sv
// Four-digit multiplexed seven-segment display of the finder operand or result,
// with double-buffered BCD so a partial conversion is never shown.
module sq_rt_display
    import sq_rt_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] a,
    input  logic [3:0] sqrt,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    logic [7:0]    val, last_val;
    logic          last_valid, start, busy, done;
    logic [11:0]   bcd;
    bcd_t          disp_buf;
    logic [CW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    assign val   = sel ? {4'b0, sqrt} : a;
    // changes arriving mid-conversion are picked up once the converter idles
    assign start = !busy && (!last_valid || (val != last_val));

    bin_to_bcd8 u_conv (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .bin   (val),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            last_val   <= '0;
            last_valid <= 1'b0;
            disp_buf   <= '0;
        end else begin
            if (start) begin
                last_val   <= val;
                last_valid <= 1'b1;
            end
            if (done) disp_buf <= bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == TC) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
        case (idx)
            2'd0: begin
                an_nxt  = AN_D0;
                seg_nxt = glyph(disp_buf.one);
            end
            2'd1: begin
                an_nxt = AN_D1;
                if (disp_buf.hun != 4'd0 || disp_buf.ten != 4'd0)
                    seg_nxt = glyph(disp_buf.ten);
            end
            2'd2: begin
                an_nxt = AN_D2;
                if (disp_buf.hun != 4'd0) seg_nxt = glyph(disp_buf.hun);
            end
            default: an_nxt = AN_D3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule
